// File: rtl/div_chk_pkg.sv
// Shared types and helpers for divided-clock monitors.
package div_chk_pkg;

  // Lock-tracking states of the checker.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int unsigned    ERR_CNT_W   = 8;
  localparam logic [7:0]     ERR_CNT_MAX = 8'hFF;

  // True when val lies within exp_v +/- tol.
  function automatic logic in_tol(input int unsigned val,
                                  input int unsigned exp_v,
                                  input int unsigned tol);
    int unsigned diff;
    diff = (val >= exp_v) ? (val - exp_v) : (exp_v - val);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/div_clk_sampler.sv
// Dual-edge sampler: turns a divided clock into an ordered pair of
// half-cycle samples per source-clock posedge, plus rise flags per step.
module div_clk_sampler (
  input  logic clkin,
  input  logic rst,
  input  logic div_clk,
  output logic samp_a,
  output logic samp_b,
  output logic rise_a,
  output logic rise_b
);

  logic s_neg;
  logic prev;

  // Capture the divided clock on the falling edge of the source clock.
  always_ff @(negedge clkin) begin
    if (rst) s_neg <= 1'b0;
    else     s_neg <= div_clk;
  end

  // Remember the last processed sample (second step of the pair).
  always_ff @(posedge clkin) begin
    if (rst) prev <= 1'b0;
    else     prev <= div_clk;
  end

  // Step a is the negedge sample, step b is the posedge sample.
  assign samp_a = s_neg;
  assign samp_b = div_clk;
  assign rise_a = s_neg & ~prev;
  assign rise_b = div_clk & ~s_neg;

endmodule

// File: rtl/div_clk_checker.sv
// Divided-clock checker: measures period and high time in half-cycles,
// tracks lock against expected values and latches timing errors.
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = 10,
  parameter int unsigned EXP_HIGH   = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CW         = 8
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          div_clk,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic          stuck,
  output logic          meas_valid,
  output logic [CW-1:0] period_meas,
  output logic [CW-1:0] high_meas,
  output logic [7:0]    err_cnt
);

  localparam logic [CW-1:0] RUN_MAX   = CW'(4 * EXP_PERIOD);
  localparam int unsigned   GW        = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);

  logic          samp_a, samp_b, rise_a, rise_b;
  logic [CW-1:0] run_cnt, high_cnt;
  logic [CW-1:0] run_a, high_a, run_b, high_b;
  logic [CW-1:0] per_val, hi_val;
  logic          closed, good, stuck_hit;
  logic [GW-1:0] good_cnt, good_inc;
  logic [7:0]    err_base, err_inc;
  state_t        state;

  div_clk_sampler u_sampler (
    .clkin   (clkin),
    .rst     (rst),
    .div_clk (div_clk),
    .samp_a  (samp_a),
    .samp_b  (samp_b),
    .rise_a  (rise_a),
    .rise_b  (rise_b)
  );

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + CW'(1);
  endfunction

  // Two ordered half-cycle steps per posedge; a rise restarts the counters
  // with the rising sample already counted, and the pre-step counts form
  // the closed period.
  always_comb begin
    run_a     = rise_a ? CW'(1) : sat_inc(run_cnt);
    high_a    = rise_a ? CW'(1) : (samp_a ? sat_inc(high_cnt) : high_cnt);
    run_b     = rise_b ? CW'(1) : sat_inc(run_a);
    high_b    = rise_b ? CW'(1) : (samp_b ? sat_inc(high_a) : high_a);
    closed    = rise_a | rise_b;
    per_val   = rise_a ? run_cnt  : run_a;
    hi_val    = rise_a ? high_cnt : high_a;
    good      = in_tol(32'(per_val), EXP_PERIOD, TOL) &&
                in_tol(32'(hi_val), EXP_HIGH, TOL);
    stuck_hit = (run_b == RUN_MAX);
  end

  // A clear in the same cycle as a new bad period restarts the count at one.
  always_comb begin
    err_base = clr ? '0 : err_cnt;
    err_inc  = (err_base == ERR_CNT_MAX) ? ERR_CNT_MAX : err_base + 8'd1;
    good_inc = good_cnt + GW'(1);
  end

  // Half-cycle run and high-time counters.
  always_ff @(posedge clkin) begin
    if (rst) begin
      run_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      run_cnt  <= run_b;
      high_cnt <= high_b;
    end
  end

  // Lock FSM with registered status and measurement outputs.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state       <= IDLE;
      good_cnt    <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      stuck       <= 1'b0;
      meas_valid  <= 1'b0;
      period_meas <= '0;
      high_meas   <= '0;
      err_cnt     <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (clr) begin
        err     <= 1'b0;
        stuck   <= 1'b0;
        err_cnt <= '0;
      end
      if (stuck_hit) begin
        stuck    <= 1'b1;
        locked   <= 1'b0;
        good_cnt <= '0;
        state    <= IDLE;
        if (state == LOCK) err <= 1'b1;
      end else if (closed) begin
        unique case (state)
          IDLE: begin
            state <= ACQ;
          end
          ACQ: begin
            meas_valid  <= 1'b1;
            period_meas <= per_val;
            high_meas   <= hi_val;
            if (good) begin
              good_cnt <= good_inc;
              if (good_inc == GOOD_LOCK) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
              err_cnt  <= err_inc;
            end
          end
          LOCK: begin
            meas_valid  <= 1'b1;
            period_meas <= per_val;
            high_meas   <= hi_val;
            if (!good) begin
              err      <= 1'b1;
              err_cnt  <= err_inc;
              locked   <= 1'b0;
              good_cnt <= '0;
              state    <= ACQ;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_clk_checker.md
# div_clk_checker

Dual-edge monitor for divided clocks generated inside the pixel-config clock tree, for example the odd-ratio, 50 %-duty divide-by-5. It samples the divided clock on both edges of the source clock and measures period and high time in half-cycle units. It compares both against expected values, reports lock, and latches timing errors. It sits beside each divider as an always-on self-check; its status bits are read by the slow-control register block.

## Interface
Parameters:
- EXP_PERIOD, 10, expected period in clkin half-cycles (10 for divide-by-5).
- EXP_HIGH, 5, expected high time in half-cycles (5 for a 50 % divide-by-5).
- TOL, 0, allowed absolute deviation in half-cycles, applied to both period and high time.
- LOCK_CNT, 4, consecutive good periods required to assert locked.
- CW, 8, width of the measurement counters; must satisfy 2^CW > 4*EXP_PERIOD.

Ports:
- clkin  in  1  source clock of the divider under check.
- rst  in  1  reset; synchronous, active-high; clock clkin.
- div_clk  in  1  divided clock under check. It is produced by flops on clkin edges, so it is not synchronized.
- clr  in  1  clears err, stuck and err_cnt; synchronous to clkin posedge.
- locked  out  1  LOCK_CNT consecutive good periods have been seen and none bad since.
- err  out  1  sticky: a bad period or a stuck condition occurred while locked.
- stuck  out  1  sticky: no rising edge for 4*EXP_PERIOD half-cycles.
- meas_valid  out  1  one-cycle pulse when period_meas/high_meas update.
- period_meas  out  CW  last measured period, in half-cycles.
- high_meas  out  CW  high half-cycles within the last period.
- err_cnt  out  8  count of bad periods, saturating at 255.

## Operation
- Sampler: s_neg is captured on each clkin negedge. At each posedge, the pair (s_neg, then div_clk) is processed as two ordered half-cycle steps. prev holds the last processed sample.
- Per step: run_cnt increments, saturating at 4*EXP_PERIOD. high_cnt increments when the sample is 1. A rising edge is a sample of 1 following prev = 0.
- A rising edge closes a period:
  - The period and high-time values are the counts before this step.
  - The counters restart with this step counted: run_cnt = 1, high_cnt = 1.
  - At most one rising edge can occur per pair.
- A period is good when |period - EXP_PERIOD| <= TOL and |high - EXP_HIGH| <= TOL.
- FSM states are IDLE, ACQ and LOCK:
  - IDLE: waits for the first rising edge, discards the partial period, then goes to ACQ. No meas_valid is issued.
  - ACQ: on each closed period, meas_valid pulses. A good period increments good_cnt; a bad one clears good_cnt and increments err_cnt. When good_cnt reaches LOCK_CNT, go to LOCK and set locked = 1.
  - LOCK: a good period keeps locked. A bad period sets err, increments err_cnt, clears locked and good_cnt, and returns to ACQ.
- Stuck: when run_cnt reaches 4*EXP_PERIOD, set stuck, clear locked and good_cnt, and go to IDLE. If in LOCK, also set err.
- clr together with a new error in the same cycle: the error wins.
- err_cnt stays at 255 once saturated.

## Timing
- Reset, sampled at posedge: all outputs become 0 and the FSM goes to IDLE. s_neg clears at the next negedge. Reset mid-period discards the partial measurement.
- period_meas, high_meas and meas_valid are registered at the same posedge whose pair contains the rising edge. Latency is 0 cycles after that edge; meas_valid is high for exactly one cycle.
- locked rises at the posedge that closes the LOCK_CNT-th good period. It falls at the posedge that closes a bad period or reaches the stuck threshold.
- Steady divide-by-5: meas_valid pulses every 5 clkin cycles.

## Structure
- Package div_chk_pkg holds the state enum (IDLE, ACQ, LOCK) and a function checking a value against EXP ± TOL.
- Sub-module div_clk_sampler contains the negedge flop and the prev register. It outputs the ordered sample pair and is reusable by other clock monitors.
- The counters, the compare logic and the FSM stay in the top level.

## Test plan
- Ideal 50 % divide-by-5, default parameters. Expect locked = 1 at the close of the 5th rising edge, and every meas_valid to show period_meas = 10, high_meas = 5. err = 0.
- Posedge-only divide-by-5 (high 4 of 10 half-cycles), TOL = 0. Expect high_meas = 4, locked to stay 0, err = 0, and err_cnt to increment on every period.
- Locked, then inject one extra-long high (period 12). Expect err = 1, locked = 0, err_cnt = 1, and relock after 4 good periods with err still 1. clr then returns err and err_cnt to 0.
- Locked, then div_clk held at 1. Expect stuck = 1 and err = 1 after 40 half-cycles (20 clkin cycles) without a rising edge, and the FSM in IDLE.
- TOL = 1 with period 11 and high 5 → locked = 1. Period 12 → bad.
- rst asserted mid-period while locked. Expect all outputs 0 at the next posedge, no meas_valid for the first partial period after release, and locked after 1 + 4 rising edges.
